// File: rtl/ppu_pkg.sv
// Shared PPU definitions: opcode encoding and the requester-ID width helper.
package ppu_pkg;

   localparam int OP_BITS = 4;

   typedef enum logic [OP_BITS-1:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_FMA = 4'd3
   } ppu_op_e;

   // Width of a requester tag; never narrower than one bit.
   function automatic int id_bits(input int num_req);
      return (num_req <= 1) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid requester at or above the pointer, with wrap.
module rr_arbiter
   import ppu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_BITS = id_bits(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   input  logic [ID_BITS-1:0] ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_BITS-1:0] grant_idx,
   output logic               any_grant
);

   // Scan from the pointer upward and take the first requester found.
   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (enable && !any_grant && req[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = ID_BITS'(idx);
         end
      end
   end

endmodule

// File: rtl/ppu_arbiter.sv
// Shares one ppu_top between NUM_REQ requesters: round-robin issue, a
// fixed-latency tag pipe, and one-hot steering of results back to their owner.
module ppu_arbiter
   import ppu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_BITS = id_bits(NUM_REQ),
   parameter int WORD    = 32,
   parameter int OP_BITS = ppu_pkg::OP_BITS,
   parameter int LATENCY = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    enable_i,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic [NUM_REQ*OP_BITS-1:0] req_op_i,
   input  logic [NUM_REQ*WORD-1:0] req_operand1_i,
   input  logic [NUM_REQ*WORD-1:0] req_operand2_i,
   input  logic [NUM_REQ*WORD-1:0] req_operand3_i,
   output logic                    ppu_in_valid_o,
   output logic [OP_BITS-1:0]      ppu_op_o,
   output logic [WORD-1:0]         ppu_operand1_o,
   output logic [WORD-1:0]         ppu_operand2_o,
   output logic [WORD-1:0]         ppu_operand3_o,
   input  logic [WORD-1:0]         ppu_result_i,
   input  logic                    ppu_out_valid_i,
   output logic [NUM_REQ-1:0]      rsp_valid_o,
   output logic [WORD-1:0]         rsp_result_o,
   output logic                    err_o
);

   typedef struct packed {
      logic               valid;
      logic [ID_BITS-1:0] id;
   } tag_t;

   logic [ID_BITS-1:0] ptr_q;
   logic [NUM_REQ-1:0] grant;
   logic [ID_BITS-1:0] grant_idx;
   logic               any_grant;
   tag_t               pipe_q [LATENCY];
   tag_t               tail;
   logic               err_q;

   // Grants are suppressed while disabled and while reset is held.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_BITS (ID_BITS)
   ) u_rr (
      .req       (req_valid_i),
      .enable    (enable_i & ~rst_i),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign req_ready_o    = grant;
   assign ppu_in_valid_o = any_grant;
   assign tail           = pipe_q[LATENCY-1];
   assign err_o          = err_q;

   // Route the granted requester's slices to ppu_top; zero when idle.
   always_comb begin
      ppu_op_o       = '0;
      ppu_operand1_o = '0;
      ppu_operand2_o = '0;
      ppu_operand3_o = '0;
      if (any_grant) begin
         ppu_op_o       = req_op_i[int'(grant_idx)*OP_BITS +: OP_BITS];
         ppu_operand1_o = req_operand1_i[int'(grant_idx)*WORD +: WORD];
         ppu_operand2_o = req_operand2_i[int'(grant_idx)*WORD +: WORD];
         ppu_operand3_o = req_operand3_i[int'(grant_idx)*WORD +: WORD];
      end
   end

   // Advance the round-robin pointer past the requester that just issued.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state is written with <= so every register samples pre-edge values.
      if (rst_i) begin
         ptr_q <= '0;
      end else if (any_grant) begin
         ptr_q <= (grant_idx == ID_BITS'(NUM_REQ-1)) ? '0 : grant_idx + ID_BITS'(1);
      end
   end

   // Tag pipe: shifts every cycle so the tail lines up with ppu_top's result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the pipe is tiny and its valid bits must clear, so every stage is reset.
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= '{valid: any_grant, id: grant_idx};
         for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // Steer a matched result to its originator; mismatches produce no strobe.
   always_comb begin
      rsp_valid_o  = '0;
      rsp_result_o = '0;
      if (!rst_i && tail.valid && ppu_out_valid_i) begin
         rsp_valid_o[tail.id] = 1'b1;
         rsp_result_o         = ppu_result_i;
      end
   end

   // Sticky flag for a lost or spurious ppu_top result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (tail.valid != ppu_out_valid_i) begin
         err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ppu_arbiter.sv
// Scoreboard bench for ppu_arbiter with a fixed-latency stand-in for ppu_top.
module tb_ppu_arbiter;
   import ppu_pkg::*;

   localparam int N  = 4;
   localparam int L  = 3;
   localparam int W  = 32;
   localparam int OB = ppu_pkg::OP_BITS;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            enable = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*OB-1:0] req_op = '0;
   logic [N*W-1:0]  opa = '0, opb = '0, opc = '0;
   logic            ppu_in_valid;
   logic [OB-1:0]   ppu_op;
   logic [W-1:0]    ppu_a, ppu_b, ppu_c;
   logic [W-1:0]    ppu_result;
   logic            ppu_out_valid;
   logic [N-1:0]    rsp_valid;
   logic [W-1:0]    rsp_result;
   logic            err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic inject = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ppu_arbiter #(.NUM_REQ(N), .WORD(W), .LATENCY(L)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_operand1_i(opa), .req_operand2_i(opb), .req_operand3_i(opc),
      .ppu_in_valid_o(ppu_in_valid), .ppu_op_o(ppu_op),
      .ppu_operand1_o(ppu_a), .ppu_operand2_o(ppu_b), .ppu_operand3_o(ppu_c),
      .ppu_result_i(ppu_result), .ppu_out_valid_i(ppu_out_valid),
      .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .err_o(err)
   );

   // Arbitrary but operand-sensitive stand-in for the PPU computation.
   function automatic logic [W-1:0] fake_ppu(input logic [OB-1:0] op,
                                             input logic [W-1:0] a, b, c);
      return (a + b) ^ (c + W'(op) * 32'h0101_0101);
   endfunction

   // ppu_top stand-in: L-cycle pipeline, flushed by the shared reset.
   logic          fp_v   [L];
   logic [W-1:0]  fp_res [L];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++) begin fp_v[i] <= 1'b0; fp_res[i] <= '0; end
      end else begin
         fp_v[0]   <= ppu_in_valid;
         fp_res[0] <= fake_ppu(ppu_op, ppu_a, ppu_b, ppu_c);
         for (int i = 1; i < L; i++) begin fp_v[i] <= fp_v[i-1]; fp_res[i] <= fp_res[i-1]; end
      end
   end
   assign ppu_out_valid = fp_v[L-1] | inject;
   assign ppu_result    = fp_res[L-1];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int          id;
      logic [W-1:0] res;
      int          due;
   } exp_t;
   exp_t sb[$];

   int  ptr_m = 0;
   bit  err_m = 1'b0;

   // Reference model of arbitration: pushes expected responses on each issue.
   always @(negedge clk) begin
      if (rst) begin
         ptr_m = 0;
         check("ready_in_reset", req_ready, '0);
         check("in_valid_in_reset", ppu_in_valid, 1'b0);
      end else begin
         int g;
         logic [N-1:0]  exp_ready;
         logic [OB-1:0] e_op;
         logic [W-1:0]  e_a, e_b, e_c;
         g = -1;
         if (enable) begin
            for (int k = 0; k < N; k++) begin
               if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
         end
         exp_ready = '0;
         e_op = '0; e_a = '0; e_b = '0; e_c = '0;
         if (g >= 0) begin
            exp_ready[g] = 1'b1;
            e_op = req_op[g*OB +: OB];
            e_a  = opa[g*W +: W];
            e_b  = opb[g*W +: W];
            e_c  = opc[g*W +: W];
         end
         check("req_ready", req_ready, exp_ready);
         check("ppu_in_valid", ppu_in_valid, g >= 0);
         check("ppu_op", ppu_op, e_op);
         check("ppu_operands", {ppu_a, ppu_b, ppu_c}, {e_a, e_b, e_c});
         if (g >= 0) begin
            sb.push_back('{id: g, res: fake_ppu(e_op, e_a, e_b, e_c), due: cyc + L});
            ptr_m = (g + 1) % N;
         end
      end
   end

   // Response monitor: pops the scoreboard when a result is due.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         err_m = 1'b0;
         check("rsp_in_reset", rsp_valid, '0);
         check("err_in_reset", err, 1'b0);
      end else begin
         bit due_now;
         bit mismatch;
         logic [N-1:0] exp_rsp;
         check("err", err, err_m);
         due_now  = (sb.size() > 0) && (sb[0].due == cyc);
         mismatch = (due_now != ppu_out_valid);
         exp_rsp  = '0;
         if (due_now && !mismatch) exp_rsp[sb[0].id] = 1'b1;
         check("rsp_valid", rsp_valid, exp_rsp);
         if (exp_rsp != '0) check("rsp_result", rsp_result, sb[0].res);
         else check("rsp_result_idle", rsp_result, '0);
         if (due_now) void'(sb.pop_front());
         if (mismatch) err_m = 1'b1;
      end
   end

   task automatic rand_data();
      for (int i = 0; i < N; i++) begin
         req_op[i*OB +: OB] = OB'($urandom_range(0, 3));
         opa[i*W +: W] = $urandom;
         opb[i*W +: W] = $urandom;
         opc[i*W +: W] = $urandom;
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic en);
      rand_data();
      req_valid = v;
      enable    = en;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, 1'b1);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;

      // Single requester 2 with a fixed ADD operation.
      rand_data();
      req_op[2*OB +: OB] = OP_ADD;
      opa[2*W +: W] = 32'h4000_0000;
      opb[2*W +: W] = 32'h4000_0000;
      req_valid = 4'b0100;
      enable    = 1'b1;
      @(posedge clk); #1;
      idle(L + 2);

      // All requesters valid for 8 cycles from a fresh pointer.
      pulse_reset();
      for (int i = 0; i < 8; i++) drive(4'b1111, 1'b1);
      idle(L + 2);

      // Move pointer to 2, then requesters 1 and 3 contend.
      drive(4'b0010, 1'b1);
      for (int i = 0; i < 3; i++) drive(4'b1010, 1'b1);
      idle(L + 2);

      // Two issues, then disabled with requests pending, then resume.
      drive(4'b1111, 1'b1);
      drive(4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) drive(4'b1111, 1'b0);
      drive(4'b1111, 1'b1);
      drive(4'b1111, 1'b1);
      idle(L + 2);

      // Spurious result with an empty tail stage, then async clear.
      rand_data();
      inject = 1'b1;
      @(posedge clk); #1;
      inject = 1'b0;
      idle(2);
      drive(4'b0110, 1'b1);
      idle(L + 1);
      check("err_sticky", err, 1'b1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("err_async_clear", err, 1'b0);
      check("rsp_async_clear", rsp_valid, '0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset with three operations in flight; they must never return.
      drive(4'b1111, 1'b1);
      drive(4'b1111, 1'b1);
      drive(4'b1111, 1'b1);
      #1;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      idle(L + 2);
      drive(4'b0001, 1'b1);
      idle(L + 2);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) drive(N'($urandom), $urandom_range(0, 7) != 0);
      idle(L + 3);

      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
